lut_port_arbiter: RTL and testbench



---
 rtl/lut_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_lut_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_port_arbiter.sv
// lut_port_arbiter
//   Shares one single-port voice-effect LUT RAM between the audio datapath
//   (reads) and the host table loader (writes). At most one RAM access is
//   issued per clock. The grant is combinational. The RAM drive is registered
//   on the cycle after the grant. Audio read data returns RD_LATENCY+1 cycles
//   after the grant. The host is never locked out for more than MAX_STARVE
//   consecutive audio grants.
//
//   Optional build macro: LUT_HOST_RDBACK_EN
//     When defined, the host can also read the table back (host_rd_req,
//     host_rd_gnt, host_rd_valid). Read data is shared on aud_rd_data.
//
// Ports
//   clk, rst_n                        system clock, async active-low reset
//   aud_req / aud_addr / aud_gnt      audio read request, address and accept
//   aud_rd_valid / aud_rd_data        audio read return
//   host_wr_valid/_addr/_data/_ready  host write request and accept
//   ram_addr/ram_wr_data/ram_wr_en    registered drive to the RAM
//   ram_rd_data                       RAM read data
//   starve_cnt                        consecutive audio wins while host waits
//   host_rd_req/_gnt/_valid           host read-back (LUT_HOST_RDBACK_EN only)
module lut_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aud_req,
  input  logic [ADDR_WIDTH-1:0] aud_addr,
  output logic                  aud_gnt,
  output logic                  aud_rd_valid,
  output logic [DATA_WIDTH-1:0] aud_rd_data,
  input  logic                  host_wr_valid,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
`ifdef LUT_HOST_RDBACK_EN
  input  logic                  host_rd_req,
  output logic                  host_rd_gnt,
  output logic                  host_rd_valid,
`endif
  output logic [2:0]            starve_cnt
);

  localparam logic [2:0] MAX_C = 3'(MAX_STARVE);

  logic                  host_req;
  logic                  aud_win;
  logic                  host_win;
  logic                  host_wr_win;
  logic                  issue;
  logic [2:0]            starve_q;
  logic [RD_LATENCY:0]   pipe_vld;
  logic                  rd_ret;
  logic [DATA_WIDTH-1:0] rd_hold;

`ifdef LUT_HOST_RDBACK_EN
  logic                  host_rd_win;
  logic [RD_LATENCY:0]   pipe_tag;

  // A pending write takes the host slot ahead of a read-back request.
  assign host_req    = host_wr_valid | host_rd_req;
  assign host_rd_win = host_win & ~host_wr_valid;
  assign issue       = aud_win | host_rd_win;
`else
  assign host_req    = host_wr_valid;
  assign issue       = aud_win;
`endif

  // Grants are gated by rst_n so that no request is accepted while reset
  // is held.
  always_comb begin
    aud_win  = 1'b0;
    host_win = 1'b0;
    if (rst_n) begin
      if (aud_req && host_req) begin
        if (starve_q >= MAX_C) host_win = 1'b1;
        else                   aud_win  = 1'b1;
      end else if (aud_req) begin
        aud_win = 1'b1;
      end else if (host_req) begin
        host_win = 1'b1;
      end
    end
  end

  assign host_wr_win   = host_win & host_wr_valid;
  assign aud_gnt       = aud_win;
  assign host_wr_ready = host_wr_win;
  assign starve_cnt    = starve_q;

  // The counter only counts audio wins that leave a host request waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else if (aud_win && host_req) starve_q <= starve_q + 3'd1;
    else starve_q <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr    <= '0;
      ram_wr_data <= '0;
      ram_wr_en   <= 1'b0;
    end else begin
      ram_wr_en <= host_wr_win;
      if (aud_win) begin
        ram_addr <= aud_addr;
      end else if (host_win) begin
        ram_addr <= host_wr_addr;
        if (host_wr_valid) ram_wr_data <= host_wr_data;
      end
    end
  end

  // Bit 0 lines up with the registered RAM address. Each further bit adds
  // one cycle of RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_vld <= '0;
    else pipe_vld <= {pipe_vld[RD_LATENCY-1:0], issue};
  end

`ifdef LUT_HOST_RDBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_tag <= '0;
    else pipe_tag <= {pipe_tag[RD_LATENCY-1:0], host_rd_win};
  end

  assign aud_rd_valid  = rd_ret & ~pipe_tag[RD_LATENCY];
  assign host_rd_valid = rd_ret &  pipe_tag[RD_LATENCY];
  assign host_rd_gnt   = host_rd_win;
`else
  assign aud_rd_valid  = rd_ret;
`endif

  assign rd_ret = pipe_vld[RD_LATENCY];

  // While a read returns, RAM data passes straight through. At all other
  // times the last returned word is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_hold <= '0;
    else if (rd_ret) rd_hold <= ram_rd_data;
  end

  assign aud_rd_data = rd_ret ? ram_rd_data : rd_hold;

endmodule

// File: tb/tb_lut_port_arbiter.sv
// Testbench for lut_port_arbiter. It uses a behavioural RAM and a scoreboard
// model. The model tracks table contents and the starvation count, and it
// keeps a queue of expected read returns.
module tb_lut_port_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aud_req = 1'b0;
  logic [AW-1:0] aud_addr = '0;
  logic          aud_gnt;
  logic          aud_rd_valid;
  logic [DW-1:0] aud_rd_data;
  logic          host_wr_valid = 1'b0;
  logic [AW-1:0] host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_wr_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_en;
  logic [DW-1:0] ram_rd_data;
  logic [2:0]    starve_cnt;
`ifdef LUT_HOST_RDBACK_EN
  logic          host_rd_req = 1'b0;
  logic          host_rd_gnt;
  logic          host_rd_valid;
`endif

  always #5 clk = ~clk;

  lut_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .aud_req(aud_req), .aud_addr(aud_addr), .aud_gnt(aud_gnt),
    .aud_rd_valid(aud_rd_valid), .aud_rd_data(aud_rd_data),
    .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_data(ram_rd_data),
`ifdef LUT_HOST_RDBACK_EN
    .host_rd_req(host_rd_req), .host_rd_gnt(host_rd_gnt),
    .host_rd_valid(host_rd_valid),
`endif
    .starve_cnt(starve_cnt)
  );

  // Write-first single-port RAM with one cycle of read latency.
  logic [DW-1:0] ram_mem [0:1023];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_addr] = ram_wr_data;
    ram_q <= ram_mem[ram_addr];
  end
  assign ram_rd_data = ram_q;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            mcnt = 0;
  logic [DW-1:0] model_mem [0:1023];
  rd_t           rdq[$];
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          exp_wen = 1'b0;
  logic [DW-1:0] exp_hold = '0;

  logic          obs_gnt, obs_rdy, obs_valid, obs_wen;
  logic [DW-1:0] obs_data, obs_wdata;
  logic [AW-1:0] obs_addr;
  logic [2:0]    obs_cnt;

  task automatic model_reset();
    mcnt      = 0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_wen   = 1'b0;
    exp_hold  = '0;
    rdq.delete();
  endtask

  // Runs one clock of stimulus and scores every output against the model.
  task automatic step(input logic a_req, input logic [AW-1:0] a_addr,
                      input logic h_val, input logic [AW-1:0] h_addr,
                      input logic [DW-1:0] h_data);
    logic          e_aud, e_host, e_valid;
    logic [DW-1:0] e_data;
    @(negedge clk);
    rst_n         = 1'b1;
    aud_req       = a_req;
    aud_addr      = a_addr;
    host_wr_valid = h_val;
    host_wr_addr  = h_addr;
    host_wr_data  = h_data;
    #1;
    obs_gnt = aud_gnt; obs_rdy = host_wr_ready; obs_valid = aud_rd_valid;
    obs_data = aud_rd_data; obs_wen = ram_wr_en; obs_addr = ram_addr;
    obs_wdata = ram_wr_data; obs_cnt = starve_cnt;

    e_aud  = a_req && (!h_val || mcnt < MAXS);
    e_host = h_val && !e_aud;
    checks++;
    if (aud_gnt !== e_aud || host_wr_ready !== e_host) begin
      errors++;
      $display("FAIL grant cyc=%0d got aud_gnt=%b host_wr_ready=%b exp %b %b",
               cyc, aud_gnt, host_wr_ready, e_aud, e_host);
    end
    checks++;
    if (starve_cnt !== 3'(mcnt)) begin
      errors++;
      $display("FAIL starve_cnt cyc=%0d got %0d exp %0d", cyc, starve_cnt, mcnt);
    end
    checks++;
    if (ram_wr_en !== exp_wen || ram_addr !== exp_addr || ram_wr_data !== exp_wdata) begin
      errors++;
      $display("FAIL ram_drive cyc=%0d got en=%b addr=%h data=%h exp en=%b addr=%h data=%h",
               cyc, ram_wr_en, ram_addr, ram_wr_data, exp_wen, exp_addr, exp_wdata);
    end
    e_valid = (rdq.size() > 0) && (rdq[0].due == cyc);
    if (e_valid) begin
      e_data   = rdq[0].data;
      exp_hold = e_data;
      void'(rdq.pop_front());
    end else begin
      e_data = exp_hold;
    end
    checks++;
    if (aud_rd_valid !== e_valid || aud_rd_data !== e_data) begin
      errors++;
      $display("FAIL rd_return cyc=%0d got valid=%b data=%h exp valid=%b data=%h",
               cyc, aud_rd_valid, aud_rd_data, e_valid, e_data);
    end

    mcnt    = (e_aud && h_val) ? mcnt + 1 : 0;
    exp_wen = e_host;
    if (e_aud) begin
      exp_addr = a_addr;
      rdq.push_back('{cyc + 2, model_mem[a_addr]});
    end
    if (e_host) begin
      exp_addr       = h_addr;
      exp_wdata      = h_data;
      model_mem[h_addr] = h_data;
    end
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; aud_req = 1'b1; host_wr_valid = 1'b1;
    host_wr_addr = 10'h155; aud_addr = 10'h0AA; host_wr_data = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({aud_gnt, host_wr_ready, aud_rd_valid, aud_rd_data, ram_addr,
           ram_wr_data, ram_wr_en, starve_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got gnt=%b rdy=%b v=%b d=%h a=%h wd=%h we=%b cnt=%0d exp all 0",
                 aud_gnt, host_wr_ready, aud_rd_valid, aud_rd_data, ram_addr,
                 ram_wr_data, ram_wr_en, starve_cnt);
      end
      @(negedge clk);
    end
    model_reset();
    step(1'b1, 10'h0AA, 1'b1, 10'h155, 16'hFFFF);
    checks++;
    if (obs_gnt !== 1'b1 || obs_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant got aud=%b host=%b exp aud=1 host=0", obs_gnt, obs_rdy);
    end
    step(1'b0, '0, 1'b1, 10'h155, 16'hFFFF);
    step(1'b0, '0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_audio_stream();
    for (int k = 0; k < 11; k++) begin
      step(k < 8, 10'(k), 1'b0, '0, '0);
      checks++;
      if (k >= 2 && k <= 9) begin
        if (obs_valid !== 1'b1 || obs_data !== 16'(16'h100 + k - 2)) begin
          errors++;
          $display("FAIL stream_data k=%0d got valid=%b data=%h exp valid=1 data=%h",
                   k, obs_valid, obs_data, 16'(16'h100 + k - 2));
        end
      end else if (obs_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_idle k=%0d got valid=%b exp 0", k, obs_valid);
      end
    end
  endtask

  task automatic test_starvation();
    logic done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 10'($urandom_range(0, 1023)), !done, 10'h3FF, 16'hBEEF);
      checks++;
      if (obs_rdy !== (k == 4)) begin
        errors++;
        $display("FAIL starve_ready k=%0d got %b exp %b", k, obs_rdy, (k == 4));
      end
      if (k >= 1 && k <= 5) begin
        checks++;
        if (obs_cnt !== 3'(k == 5 ? 0 : k)) begin
          errors++;
          $display("FAIL starve_seq k=%0d got %0d exp %0d", k, obs_cnt, (k == 5 ? 0 : k));
        end
      end
      if (k == 5) begin
        checks++;
        if (obs_wen !== 1'b1 || obs_addr !== 10'h3FF || obs_wdata !== 16'hBEEF || obs_gnt !== 1'b1) begin
          errors++;
          $display("FAIL starve_write got en=%b addr=%h data=%h aud_gnt=%b exp 1 3ff beef 1",
                   obs_wen, obs_addr, obs_wdata, obs_gnt);
        end
      end
      if (obs_rdy) done = 1'b1;
    end
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_write_then_read();
    step(1'b0, '0, 1'b1, 10'h005, 16'h1234);
    step(1'b1, 10'h005, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, '0, '0);
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 16'h1234) begin
      errors++;
      $display("FAIL wr_then_rd got valid=%b data=%h exp 1 1234", obs_valid, obs_data);
    end
    step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    logic          a_req = 1'b0, h_val = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_data = '0;
    for (int k = 0; k < 400; k++) begin
      if (!a_req) a_req = ($urandom_range(0, 3) != 0);
      if (!h_val) begin
        h_val  = ($urandom_range(0, 2) == 0);
        h_addr = 10'($urandom_range(0, 63));
        h_data = 16'($urandom);
      end
      step(a_req, 10'($urandom_range(0, 63)), h_val, h_addr, h_data);
      if (obs_gnt) a_req = 1'b0;
      if (obs_rdy) h_val = 1'b0;
    end
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] old;
    step(1'b1, 10'h020, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b0; aud_req = 1'b0; host_wr_valid = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b0, '0, '0);
      checks++;
      if (obs_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale_valid k=%0d got %b exp 0", k, obs_valid);
      end
    end
    old = model_mem[10'h033];
    step(1'b0, '0, 1'b1, 10'h033, 16'h5555);
    @(negedge clk);
    host_wr_valid = 1'b0;
    #1;
    checks++;
    if (ram_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_wen_pre got %b exp 1", ram_wr_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_wen_drop got %b exp 0", ram_wr_en);
    end
    model_mem[10'h033] = old;
    model_reset();
    cyc++;
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

`ifdef LUT_HOST_RDBACK_EN
  task automatic test_host_rdback();
    step(1'b0, '0, 1'b1, 10'h010, 16'h0AA0);
    step(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    host_rd_req = 1'b1; host_wr_addr = 10'h010;
    #1;
    checks++;
    if (host_rd_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rdback_gnt got %b exp 1", host_rd_gnt);
    end
    @(negedge clk);
    host_rd_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (host_rd_valid !== 1'b1 || aud_rd_valid !== 1'b0 || aud_rd_data !== 16'h0AA0) begin
      errors++;
      $display("FAIL rdback_ret got hv=%b av=%b data=%h exp 1 0 0aa0",
               host_rd_valid, aud_rd_valid, aud_rd_data);
    end
    exp_addr = 10'h010;
    exp_hold = 16'h0AA0;
    cyc += 3;
    step(1'b0, '0, 1'b0, '0, '0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i]   = 16'(i + 16'h100);
      model_mem[i] = 16'(i + 16'h100);
    end
    test_reset();
    test_audio_stream();
    test_starvation();
    test_write_then_read();
    test_random();
    test_reset_mid();
`ifdef LUT_HOST_RDBACK_EN
    test_host_rdback();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
